// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory req/ack port, branch redirect and
// the valid/ready hand-off to decode.
//   master : the fetch queue (drives mem_req/mem_addr and the out_* head signals)
//   slave  : the environment (memory, MEM-stage redirect, decode)
interface instr_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_4;
  logic        out_ready;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc_4,
    input  mem_ack, mem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc_4,
    output mem_ack, mem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end ahead of the IF/ID register. Owns the fetch PC,
// issues word fetches over req/ack, buffers {instr, pc+4} in a DEPTH-entry FIFO
// and presents the head to decode over valid/ready. A redirect flushes the FIFO,
// abandons the in-flight fetch and restarts at the target.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   bus        : instr_fetch_queue_if.master (memory, redirect, decode hand-off)
//   stall_cnt  : cycles decode was ready but the queue was empty
//                (present only when IFQ_PERF_EN is defined)
// Optional feature macro: IFQ_PERF_EN
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  instr_fetch_queue_if.master   bus
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]    state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [CW-1:0] count, count_n, count_pop;
  logic [PW-1:0] rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic          push, pop;
  logic [31:0]   pc_plus4;
  logic          mem_req_n;
  logic [31:0]   mem_addr_n;
  logic          out_valid_n;
  logic [31:0]   out_instr_n, out_pc_4_n;

  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc4   [DEPTH];

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= RESET_PC;
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_pc_4  <= '0;
    end else begin
      state         <= state_n;
      fetch_pc      <= fetch_pc_n;
      count         <= count_n;
      rd_ptr        <= rd_ptr_n;
      wr_ptr        <= wr_ptr_n;
      bus.mem_req   <= mem_req_n;
      bus.mem_addr  <= mem_addr_n;
      bus.out_valid <= out_valid_n;
      bus.out_instr <= out_instr_n;
      bus.out_pc_4  <= out_pc_4_n;
    end
  end

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.mem_rdata;
      fifo_pc4[wr_ptr]   <= pc_plus4;
    end
  end

  // Next-state, queue bookkeeping and next output values.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    push       = 1'b0;
    pop        = bus.out_valid & bus.out_ready;
    pc_plus4   = fetch_pc + 32'd4;
    count_pop  = count;
    count_n    = count;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;

    if (bus.redirect) begin
      // Flush: no push or pop this cycle; an ack on the stale address completes it.
      pop        = 1'b0;
      count_n    = '0;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      fetch_pc_n = bus.redirect_pc & ~32'h3;
      case (state)
        S_IDLE:  state_n = S_REQ;
        S_REQ:   state_n = bus.mem_ack ? S_REQ : S_DROP;
        S_DROP:  state_n = bus.mem_ack ? S_REQ : S_DROP;
        default: state_n = S_IDLE;
      endcase
    end else begin
      count_pop = count - CW'(pop);
      case (state)
        S_IDLE: begin
          if (count_pop < CW'(DEPTH)) state_n = S_REQ;
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            push       = 1'b1;
            fetch_pc_n = pc_plus4;
            state_n    = ((count_pop + CW'(1)) < CW'(DEPTH)) ? S_REQ : S_IDLE;
          end
        end
        S_DROP: begin
          if (bus.mem_ack) state_n = S_REQ;
        end
        default: state_n = S_IDLE;
      endcase
      count_n  = count_pop + CW'(push);
      rd_ptr_n = rd_ptr + PW'(pop);
      wr_ptr_n = wr_ptr + PW'(push);
    end

    // DROP keeps the stale address on the bus until its ack arrives.
    mem_req_n  = (state_n != S_IDLE);
    mem_addr_n = (state_n == S_DROP) ? bus.mem_addr : fetch_pc_n;

    // Head after this edge: bypass the pushed word when the queue drains to it.
    out_valid_n = (count_n != '0);
    out_instr_n = '0;
    out_pc_4_n  = '0;
    if (count_n != '0) begin
      if (push && (count_pop == '0)) begin
        out_instr_n = bus.mem_rdata;
        out_pc_4_n  = pc_plus4;
      end else begin
        out_instr_n = fifo_instr[rd_ptr_n];
        out_pc_4_n  = fifo_pc4[rd_ptr_n];
      end
    end
  end

`ifdef IFQ_PERF_EN
  // Saturating count of cycles decode was ready but had nothing to take.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (bus.out_ready && !bus.out_valid && !bus.redirect &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue. Memory returns addr ^ 32'hDEAD0000.
module tb_instr_fetch_queue;
  logic clk;
  logic rstn;
  int   errors;
  int   checks;
`ifdef IFQ_PERF_EN
  logic [31:0] stall_cnt;
`endif

  instr_fetch_queue_if ifc ();

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifc)
`ifdef IFQ_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  assign ifc.mem_rdata = ifc.mem_addr ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with the given stimulus; returns #1 after the edge that precedes E1.
  task automatic do_reset(input logic ack, input logic ready);
    rstn            = 1'b0;
    ifc.mem_ack     = ack;
    ifc.out_ready   = ready;
    ifc.redirect    = 1'b0;
    ifc.redirect_pc = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // 1: reset values, then one fetch per cycle with no bubbles
    do_reset(1'b1, 1'b1);
    rstn = 1'b0;
    #1;
    check("rst_mem_req",   32'(ifc.mem_req), 32'd0);
    check("rst_mem_addr",  ifc.mem_addr, 32'h0040_0000);
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_out_instr", ifc.out_instr, 32'd0);
    check("rst_out_pc_4",  ifc.out_pc_4, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("s1_first_req",  32'(ifc.mem_req), 32'd1);
    check("s1_first_addr", ifc.mem_addr, 32'h0040_0000);
    check("s1_first_nv",   32'(ifc.out_valid), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      check("s1_addr",  ifc.mem_addr, 32'h0040_0000 + 32'd4 * 32'(k - 1));
      check("s1_valid", 32'(ifc.out_valid), 32'd1);
      check("s1_pc4",   ifc.out_pc_4, 32'h0040_0000 + 32'd4 * 32'(k - 1));
      check("s1_instr", ifc.out_instr,
            (32'h0040_0000 + 32'd4 * 32'(k - 2)) ^ 32'hDEAD_0000);
    end

    // 2: fill to DEPTH with decode stalled, then drain in order
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    check("s2_req_before_full", 32'(ifc.mem_req), 32'd1);
    tick();
    check("s2_full_req", 32'(ifc.mem_req), 32'd0);
    check("s2_full_pc4", ifc.out_pc_4, 32'h0040_0004);
    tick();
    check("s2_idle_req", 32'(ifc.mem_req), 32'd0);
    ifc.out_ready = 1'b1;
    tick();
    check("s2_resume_req",  32'(ifc.mem_req), 32'd1);
    check("s2_resume_addr", ifc.mem_addr, 32'h0040_0010);
    check("s2_drain0",      ifc.out_pc_4, 32'h0040_0008);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s2_drain", ifc.out_pc_4, 32'h0040_000C + 32'd4 * 32'(i));
    end
    check("s2_drain_instr", ifc.out_instr, 32'h0040_0010 ^ 32'hDEAD_0000);

    // 3: ack arrives three cycles into the request
    do_reset(1'b0, 1'b1);
    tick();
    check("s3_hold0", ifc.mem_addr, 32'h0040_0000);
    tick();
    check("s3_hold1", ifc.mem_addr, 32'h0040_0000);
    check("s3_req1",  32'(ifc.mem_req), 32'd1);
    tick();
    check("s3_hold2", ifc.mem_addr, 32'h0040_0000);
    check("s3_nv",    32'(ifc.out_valid), 32'd0);
    ifc.mem_ack = 1'b1;
    tick();
    ifc.mem_ack = 1'b0;
    check("s3_valid", 32'(ifc.out_valid), 32'd1);
    check("s3_pc4",   ifc.out_pc_4, 32'h0040_0004);
    check("s3_next",  ifc.mem_addr, 32'h0040_0004);
    tick();
    check("s3_one_entry", 32'(ifc.out_valid), 32'd0);

    // 4: redirect while a request is pending; stale word dropped
    do_reset(1'b0, 1'b1);
    tick();
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 32'h0040_0103;
    tick();
    ifc.redirect = 1'b0;
    check("s4_stale_addr", ifc.mem_addr, 32'h0040_0000);
    check("s4_stale_req",  32'(ifc.mem_req), 32'd1);
    tick();
    ifc.mem_ack = 1'b1;
    tick();
    check("s4_dropped",  32'(ifc.out_valid), 32'd0);
    check("s4_new_addr", ifc.mem_addr, 32'h0040_0100);
    tick();
    check("s4_valid", 32'(ifc.out_valid), 32'd1);
    check("s4_pc4",   ifc.out_pc_4, 32'h0040_0104);
    check("s4_instr", ifc.out_instr, 32'h0040_0100 ^ 32'hDEAD_0000);

    // 5: redirect with pop pending on a full queue
    do_reset(1'b1, 1'b0);
    repeat (5) tick();
    check("s5_full_valid", 32'(ifc.out_valid), 32'd1);
    ifc.out_ready   = 1'b1;
    ifc.redirect    = 1'b1;
    ifc.redirect_pc = 32'h0050_0000;
    tick();
    ifc.redirect = 1'b0;
    check("s5_flush_valid", 32'(ifc.out_valid), 32'd0);
    check("s5_flush_instr", ifc.out_instr, 32'd0);
    check("s5_flush_pc4",   ifc.out_pc_4, 32'd0);
    check("s5_req",         32'(ifc.mem_req), 32'd1);
    check("s5_addr",        ifc.mem_addr, 32'h0050_0000);
    tick();
    check("s5_first_pc4", ifc.out_pc_4, 32'h0050_0004);
    check("s5_next_addr", ifc.mem_addr, 32'h0050_0004);

    // 6: asynchronous reset mid-request with two entries queued
    do_reset(1'b1, 1'b0);
    repeat (3) tick();
    ifc.mem_ack = 1'b0;
    check("s6_pre_valid", 32'(ifc.out_valid), 32'd1);
    check("s6_pre_addr",  ifc.mem_addr, 32'h0040_0008);
    #3;
    rstn = 1'b0;
    #1;
    check("s6_async_req",   32'(ifc.mem_req), 32'd0);
    check("s6_async_addr",  ifc.mem_addr, 32'h0040_0000);
    check("s6_async_valid", 32'(ifc.out_valid), 32'd0);
    check("s6_async_instr", ifc.out_instr, 32'd0);
    check("s6_async_pc4",   ifc.out_pc_4, 32'd0);
    ifc.out_ready = 1'b1;
    tick();
`ifdef IFQ_PERF_EN
    check("s6_stall_rst", stall_cnt, 32'd0);
`endif
    rstn = 1'b1;
    tick();
    check("s6_restart_req",  32'(ifc.mem_req), 32'd1);
    check("s6_restart_addr", ifc.mem_addr, 32'h0040_0000);
    tick();
    tick();
`ifdef IFQ_PERF_EN
    check("s6_stall_cnt", stall_cnt, 32'd3);
`endif
    check("s6_still_empty", 32'(ifc.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
